parity_check_sched: RTL and testbench



---
 rtl/parity_sched_pkg.sv | 24 ++
 rtl/parity_core.sv | 11 +
 rtl/parity_check_sched.sv | 156 +++++++++++++++
 tb/tb_parity_check_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the two-port parity-check scheduler.
// Holds the FSM encoding, frame/counter widths and the port indices.
package parity_sched_pkg;

    localparam int FRM_W = 5;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counters hold at the top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/parity_core.sv
// Even-parity checker: pe=1 when the XOR of data and parity bits is odd.
module parity_core
    import parity_sched_pkg::*;
(
    input  logic [FRM_W-1:0] frame,
    output logic             pe
);

    assign pe = ^frame;

endmodule

// File: rtl/parity_check_sched.sv
// Two-requester parity-check scheduler: arbitrates, captures a frame,
// checks its parity and returns a one-cycle result with per-port error counts.
module parity_check_sched
    import parity_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [FRM_W-1:0] frm0,
    input  logic [FRM_W-1:0] frm1,
    input  logic             clr_cnt,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic             busy
);

    logic [1:0]       r_rst_sync;
    state_t           r_state;
    logic             r_last_grant;
    logic             r_sel;
    logic [FRM_W-1:0] r_frame;
    logic             r_res;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_done0;
    logic             r_done1;
    logic             r_err0;
    logic             r_err1;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_pe;
    logic             w_any_req;
    logic             w_pick;
    logic             w_run;

    parity_core u_core (
        .frame (r_frame),
        .pe    (w_pe)
    );

    // Reset release is delayed two edges so the FSM never starts on a metastable release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run     = r_rst_sync[1];
    assign w_any_req = req0 | req1;

    // On contention the port that was not served last wins.
    always_comb begin
        w_pick = PORT0;
        if (req0 && req1) begin
            w_pick = ~r_last_grant;
        end else if (req1) begin
            w_pick = PORT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT1;
            r_sel        <= PORT0;
            r_frame      <= '0;
            r_res        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_busy       <= 1'b0;
        end else if (w_run) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_GRANT;
                        r_sel   <= w_pick;
                        r_ack0  <= (w_pick == PORT0);
                        r_ack1  <= (w_pick == PORT1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_frame <= (r_sel == PORT1) ? frm1 : frm0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_res   <= w_pe;
                    r_done0 <= (r_sel == PORT0);
                    r_done1 <= (r_sel == PORT1);
                    r_err0  <= (r_sel == PORT0) & w_pe;
                    r_err1  <= (r_sel == PORT1) & w_pe;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done0      <= 1'b0;
                    r_done1      <= 1'b0;
                    r_err0       <= 1'b0;
                    r_err1       <= 1'b0;
                    r_last_grant <= r_sel;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Clear has priority over the increment landing in the same CHECK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_run) begin
            if (clr_cnt) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (r_state == ST_CHECK && w_pe) begin
                if (r_sel == PORT0) begin
                    r_cnt0 <= sat_inc(r_cnt0);
                end else begin
                    r_cnt1 <= sat_inc(r_cnt1);
                end
            end
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign busy     = r_busy;
    assign err_cnt0 = r_cnt0;
    assign err_cnt1 = r_cnt1;

endmodule

// File: tb/tb_parity_check_sched.sv
// Directed self-checking bench for parity_check_sched; all outputs are
// sampled on the falling edge and inputs change there too.
module tb_parity_check_sched;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [4:0] frm0;
    logic [4:0] frm1;
    logic       clr_cnt;
    logic       ack0;
    logic       ack1;
    logic       done0;
    logic       done1;
    logic       err0;
    logic       err1;
    logic [7:0] err_cnt0;
    logic [7:0] err_cnt1;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    parity_check_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .frm0     (frm0),
        .frm1     (frm1),
        .clr_cnt  (clr_cnt),
        .ack0     (ack0),
        .ack1     (ack1),
        .done0    (done0),
        .done1    (done1),
        .err0     (err0),
        .err1     (err1),
        .err_cnt0 (err_cnt0),
        .err_cnt1 (err_cnt1),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    // Holds reset, releases it and waits out the internal synchroniser.
    task automatic do_reset;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic send_p0_frame;
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({ack0, ack1, done0, done1, err0, err1, busy} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b want=0000000", {ack0, ack1, done0, done1, err0, err1, busy});
        end
        checks++;
        if ({err_cnt0, err_cnt1} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_counters got=%h/%h want=00/00", err_cnt0, err_cnt1);
        end
        rst_n = 1'b1;
        req0  = 1'b1;
        step();
        req0  = 1'b0;
        checks++;
        if (busy !== 1'b0 || ack0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sync_first_edge got busy=%b ack0=%b want 0/0", busy, ack0);
        end
        repeat (2) step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sync_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_basic_port0;
        frm0 = 5'b1011_1;
        req0 = 1'b1;
        step();
        checks++;
        if ({ack0, ack1, busy} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL p0_ack got=%b want=101", {ack0, ack1, busy});
        end
        req0 = 1'b0;
        step();
        frm0 = 5'b0000_1;
        checks++;
        if ({ack0, done0, busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL p0_check got=%b want=001", {ack0, done0, busy});
        end
        step();
        checks++;
        if ({done0, err0, done1, err1} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL p0_done got=%b want=1000", {done0, err0, done1, err1});
        end
        step();
        checks++;
        if ({done0, busy} !== 2'b00 || err_cnt0 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL p0_end got done=%b busy=%b cnt0=%0d want 0/0/0", done0, busy, err_cnt0);
        end
    endtask

    task automatic test_error_port1;
        frm1 = 5'b1000_0;
        req1 = 1'b1;
        step();
        checks++;
        if ({ack0, ack1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL p1_ack got=%b want=01", {ack0, ack1});
        end
        req1 = 1'b0;
        repeat (2) step();
        checks++;
        if ({done1, err1, done0, err0} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL p1_done got=%b want=1100", {done1, err1, done0, err0});
        end
        checks++;
        if (err_cnt1 !== 8'd1 || err_cnt0 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL p1_count got=%0d/%0d want=1/0", err_cnt1, err_cnt0);
        end
        step();
        checks++;
        if ({done1, err1} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL p1_err_clear got=%b want=00", {done1, err1});
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        int         ph;
        int         port;
        do_reset();
        frm0 = 5'b1011_1;
        frm1 = 5'b1011_1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            step();
            ph   = s % 4;
            port = ((s - 1) / 4) % 2;
            exp  = {ph == 1 && port == 0, ph == 1 && port == 1,
                    ph == 3 && port == 0, ph == 3 && port == 1};
            checks++;
            if ({ack0, ack1, done0, done1} !== exp) begin
                failures++;
                $display("[TB] FAIL alt_step%0d got=%b want=%b", s, {ack0, ack1, done0, done1}, exp);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || err_cnt0 !== 8'd0 || err_cnt1 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL alt_end got busy=%b cnt=%0d/%0d want 0/0/0", busy, err_cnt0, err_cnt1);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        frm0 = 5'b0000_1;
        for (int i = 0; i < 254; i++) send_p0_frame();
        checks++;
        if (err_cnt0 !== 8'd254) begin
            failures++;
            $display("[TB] FAIL sat_254 got=%0d want=254", err_cnt0);
        end
        for (int i = 0; i < 6; i++) send_p0_frame();
        checks++;
        if (err_cnt0 !== 8'd255 || err_cnt1 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL sat_255 got=%0d/%0d want=255/0", err_cnt0, err_cnt1);
        end
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++;
        if (err_cnt0 !== 8'd0 || {done0, err0} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL clr_wins got cnt=%0d done/err=%b want 0/11", err_cnt0, {done0, err0});
        end
        step();
        checks++;
        if (err_cnt0 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL clr_hold got=%0d want=0", err_cnt0);
        end
    endtask

    task automatic test_reset_mid;
        frm1 = 5'b1000_0;
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        repeat (3) step();
        checks++;
        if (err_cnt1 !== 8'd1) begin
            failures++;
            $display("[TB] FAIL mid_pre_cnt1 got=%0d want=1", err_cnt1);
        end
        frm0 = 5'b0000_1;
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done0, err0} !== 3'b000 || err_cnt0 !== 8'd0 || err_cnt1 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL mid_async got flags=%b cnt=%0d/%0d want 000/0/0", {busy, done0, err0}, err_cnt0, err_cnt1);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({done0, done1, busy} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL mid_no_done%0d got=%b want=000", i, {done0, done1, busy});
            end
        end
        frm0 = 5'b1011_1;
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        checks++;
        if ({ack0, ack1} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL mid_prio got=%b want=10", {ack0, ack1});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) step();
        checks++;
        if ({done0, err0} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL mid_done got=%b want=10", {done0, err0});
        end
        step();
        checks++;
        if (busy !== 1'b0 || err_cnt0 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL mid_end got busy=%b cnt0=%0d want 0/0", busy, err_cnt0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        frm0    = 5'b0;
        frm1    = 5'b0;
        clr_cnt = 1'b0;
        test_reset();
        test_basic_port0();
        test_error_port1();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
